// File: rtl/master_wrapper.sv
// master_wrapper
//   Bus initiator that bridges a single-outstanding CPU memory port onto the
//   shared AHB-style system bus. Each CPU request is latched, bus ownership is
//   requested, then one address phase and one data phase are driven. The
//   block waits for HReady (or a timeout) and returns a one-cycle completion
//   pulse with an error flag and read data.
//
// Ports
//   clk, rst          : clock, synchronous active-low reset
//   cpu_req/write/addr/wdata : CPU request, sampled only in IDLE
//   cpu_rdata/done/error/busy : CPU response and status
//   HBusReq / HGrant  : arbiter handshake
//   HAddress, HWrite, HTrans, HWrite_data : address and data phase outputs
//   HRead_data, HReady, HResp : slave response
module master_wrapper #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_error,
  output logic        cpu_busy,
  output logic        HBusReq,
  input  logic        HGrant,
  output logic [31:0] HAddress,
  output logic        HWrite,
  output logic [1:0]  HTrans,
  output logic [31:0] HWrite_data,
  input  logic [31:0] HRead_data,
  input  logic        HReady,
  input  logic [1:0]  HResp
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_DATA, S_RESP} state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q,   err_d;
  logic [7:0]  cnt_q,   cnt_d;

  // Only HResp[0] carries meaning; the other bit is deliberately ignored.
  logic unused_resp;
  assign unused_resp = HResp[1];

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          write_d = cpu_write;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (HGrant) state_d = S_ADDR;
      end
      S_ADDR: begin
        cnt_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: begin
        if (HReady) begin
          if (!write_q) rdata_d = HRead_data;
          err_d   = HResp[0];
          state_d = S_RESP;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bus outputs come straight from the latched request registers, so they
  // never follow the CPU inputs while a transfer is in flight.
  assign HAddress    = addr_q;
  assign HWrite      = write_q;
  assign HWrite_data = wdata_q;
  assign HTrans      = (state_q == S_ADDR) ? 2'b10 : 2'b00;
  assign HBusReq     = (state_q == S_REQ) || (state_q == S_ADDR) || (state_q == S_DATA);
  assign cpu_busy    = (state_q != S_IDLE);
  assign cpu_done    = (state_q == S_RESP);
  assign cpu_error   = (state_q == S_RESP) && err_q;
  assign cpu_rdata   = rdata_q;

endmodule

// File: tb/tb_master_wrapper.sv
// tb_master_wrapper
//   Transaction-level check of master_wrapper. Each transaction is described
//   by its direction, grant delay, HReady wait count and response; the bench
//   derives the expected cycle of every bus event and the returned data from
//   those numbers and compares cycle by cycle.
module tb_master_wrapper;

  localparam int TO = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_write;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_done, cpu_error, cpu_busy;
  logic        HBusReq, HGrant, HWrite, HReady;
  logic [31:0] HAddress, HWrite_data, HRead_data;
  logic [1:0]  HTrans, HResp;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model_rdata = '0;

  master_wrapper #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .cpu_error(cpu_error), .cpu_busy(cpu_busy),
    .HBusReq(HBusReq), .HGrant(HGrant), .HAddress(HAddress),
    .HWrite(HWrite), .HTrans(HTrans), .HWrite_data(HWrite_data),
    .HRead_data(HRead_data), .HReady(HReady), .HResp(HResp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busreq"}, 32'(HBusReq), 0);
    check({tag, "_hwrite"}, 32'(HWrite), 0);
    check({tag, "_done"},   32'(cpu_done), 0);
    check({tag, "_err"},    32'(cpu_error), 0);
    check({tag, "_busy"},   32'(cpu_busy), 0);
    check({tag, "_haddr"},  HAddress, 0);
    check({tag, "_hwdata"}, HWrite_data, 0);
    check({tag, "_rdata"},  cpu_rdata, 0);
    check({tag, "_htrans"}, 32'(HTrans), 0);
  endtask

  // One transfer. g = grant-wait cycles in REQ, w = HReady=0 cycles in DATA
  // before HReady (w >= TO means HReady never comes and the transfer times out).
  // Called aligned to cycle 0 (just after an edge); returns aligned to the
  // cycle after RESP.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int g, input int w,
                         input logic [1:0] resp);
    bit   to      = (w >= TO);
    int   data_n  = to ? TO : w + 1;
    int   addr_c  = 2 + g;
    int   data_c  = 3 + g;
    int   done_c  = data_c + data_n;
    int   hrdy_c  = data_c + w;
    logic [31:0] exp_rd  = (!wr && !to) ? rd : model_rdata;
    bit   exp_err = to ? 1'b1 : resp[0];
    for (int c = 0; c <= done_c; c++) begin
      if (c == 0) begin
        cpu_req = 1'b1; cpu_write = wr; cpu_addr = addr; cpu_wdata = wd;
      end else begin
        // Garbage on the request fields while busy; a stray request in RESP.
        cpu_req   = (c == done_c) ? 1'($urandom_range(0, 1)) : 1'b0;
        cpu_write = 1'($urandom_range(0, 1));
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
      end
      if (c >= 1 && c <= 1 + g) HGrant = (c == 1 + g);
      else                      HGrant = 1'($urandom_range(0, 1));
      if (c >= data_c && c < done_c) HReady = (!to && c == hrdy_c);
      else                           HReady = 1'($urandom_range(0, 1));
      if (!to && c == hrdy_c) begin
        HRead_data = rd; HResp = resp;
      end else begin
        HRead_data = $urandom; HResp = 2'($urandom_range(0, 3));
      end

      check("busy",   32'(cpu_busy), 32'(c >= 1));
      check("busreq", 32'(HBusReq),  32'(c >= 1 && c < done_c));
      check("htrans", 32'(HTrans),   (c == addr_c) ? 32'd2 : 32'd0);
      check("done",   32'(cpu_done), 32'(c == done_c));
      if (c >= addr_c && c < done_c) begin
        check("haddr",  HAddress,     addr);
        check("hwrite", 32'(HWrite),  32'(wr));
      end
      if (c >= data_c && c < done_c) check("hwdata", HWrite_data, wd);
      if (c == done_c) begin
        check("error", 32'(cpu_error), 32'(exp_err));
        check("rdata", cpu_rdata,      exp_rd);
      end
      tick();
    end
    cpu_req = 1'b0;
    model_rdata = exp_rd;
  endtask

  initial begin
    rst = 1'b0; cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    HGrant = 1'b0; HReady = 1'b0; HRead_data = '0; HResp = 2'b00;
    tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();
    check("idle_busy", 32'(cpu_busy), 0);

    // Directed cases from the test plan.
    run_txn(1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0, 2'b00);
    run_txn(1'b1, 32'h0000_0200, 32'h1234_5678, 32'hFFFF_0000, 3, 2, 2'b00);
    run_txn(1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_0001, 1, 0, 2'b01);
    run_txn(1'b0, 32'h0000_0400, 32'h0, 32'hCAFE_0002, 0, 1, 2'b10);
    run_txn(1'b0, 32'h0000_0500, 32'h0, 32'h5555_AAAA, 2, TO + 3, 2'b00);
    run_txn(1'b1, 32'h0000_0600, 32'hA5A5_A5A5, 32'h0, 0, TO - 1, 2'b11);

    // Randomized transfers, including timeouts (w >= TO).
    for (int i = 0; i < 40; i++)
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
              $urandom_range(0, 4), $urandom_range(0, TO + 1),
              2'($urandom_range(0, 3)));

    // Reset asserted for one cycle during DATA discards the transfer.
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_0700; cpu_wdata = 32'h1;
    HGrant = 1'b1; HReady = 1'b0;
    tick();                       // REQ
    cpu_req = 1'b0;
    tick();                       // ADDR
    HGrant = 1'b0;
    tick();                       // DATA
    check("pre_rst_busreq", 32'(HBusReq), 1);
    rst = 1'b0;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b1;
    model_rdata = '0;
    for (int c = 0; c < 20; c++) begin
      HReady = 1'($urandom_range(0, 1));
      HGrant = 1'($urandom_range(0, 1));
      HRead_data = $urandom;
      tick();
      check("midrst_nodone", 32'(cpu_done), 0);
      check("midrst_idle",   32'(cpu_busy), 0);
    end

    // Block still works after the aborted transfer.
    run_txn(1'b0, 32'h0000_0800, 32'h0, 32'h0BAD_F00D, 1, 1, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/master_wrapper.md
# master_wrapper

Bus initiator bridging the CPU's single-outstanding memory port onto the shared AHB-style system bus. It requests bus ownership, drives one address phase and one data phase per transfer, and waits for the selected slave's HReady. It then returns read data and a completion or error pulse to the CPU. It is the initiator-side counterpart of the slave wrappers on the same bus: one instance per CPU port (instruction, data).

## Interface
Parameters:
- TIMEOUT, 16: maximum cycles spent in DATA without HReady before the transfer is aborted with error; legal range 2..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset. Sampled on the rising edge of clk; rst=0 resets the block.
- cpu_req  in  1  request strobe; sampled only in IDLE.
- cpu_write  in  1  1 = write, 0 = read; sampled with cpu_req.
- cpu_addr  in  32  byte address; sampled with cpu_req.
- cpu_wdata  in  32  write data; sampled with cpu_req.
- cpu_rdata  out  32  read data; valid while cpu_done=1 and held until the next completed read.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_error  out  1  qualifies cpu_done; 1 = slave error or timeout.
- cpu_busy  out  1  1 whenever state != IDLE; CPU must not change request fields while busy.
- HBusReq  out  1  bus ownership request to the arbiter.
- HGrant  in  1  arbiter grant.
- HAddress  out  32  address-phase address.
- HWrite  out  1  address-phase direction.
- HTrans  out  2  2'b10 NONSEQ in ADDR, otherwise 2'b00 IDLE.
- HWrite_data  out  32  write data; driven during DATA.
- HRead_data  in  32  read data from the selected slave.
- HReady  in  1  slave completion.
- HResp  in  2  HResp[0]=1 means ERROR; all other encodings complete normally.

## Operation
- Request latch: in IDLE with cpu_req=1, capture cpu_write, cpu_addr and cpu_wdata into internal registers, then go to REQ. The bus is always driven from these latched copies, never directly from the CPU inputs.
- FSM states are IDLE, REQ, ADDR, DATA, RESP.
  - IDLE: cpu_req=1 -> REQ.
  - REQ: HBusReq=1. HGrant=1 -> ADDR; otherwise stay in REQ, with no limit on how long.
  - ADDR: exactly one cycle. HTrans=NONSEQ; HAddress and HWrite carry the latched values. HBusReq stays 1. Always goes to DATA.
  - DATA: HTrans=IDLE; HWrite_data = latched data; HAddress and HWrite hold their values; HBusReq=1; the timeout counter increments each cycle.
    - HReady=1: capture HRead_data (reads only) and err = HResp[0], then go to RESP.
    - Counter reaches TIMEOUT-1 with HReady=0: err=1, go to RESP, keep cpu_rdata unchanged.
  - RESP: cpu_done=1, cpu_error=err, HBusReq=0. Always goes to IDLE.
- HGrant is ignored outside REQ. Losing the grant during ADDR or DATA does not abort the transfer.
- Timeout counter: 8 bits, cleared on entry to DATA, saturates and never wraps.
- On writes, cpu_rdata keeps its previous value.
- On a read that ends in a slave error, HRead_data is still captured into cpu_rdata.
- Reset mid-operation: rst=0 in any state returns the FSM to IDLE at the next edge and discards the pending request; no cpu_done is produced.

## Timing
- Reset values:
  - 0: HBusReq, HWrite, cpu_done, cpu_error, cpu_busy, internal error flag, timeout counter.
  - 32'h0: HAddress, HWrite_data, cpu_rdata.
  - 2'b00: HTrans.
  - State: IDLE.
- All outputs are registered or decoded from the state register; there is no combinational path from any input to any output.
- Minimum latency, with cpu_req=1 at cycle 0:
  - REQ at cycle 1 (HBusReq=1). With HGrant=1 at cycle 1, ADDR at cycle 2.
  - DATA at cycle 3. With HReady=1 at cycle 3, cpu_done=1 at cycle 4.
  - IDLE at cycle 5; the earliest next accepted cpu_req is cycle 5.
- Each grant-wait cycle in REQ and each HReady=0 cycle in DATA adds one cycle of latency.
- cpu_busy=1 from cycle 1 through the RESP cycle inclusive.

## Test plan
- Read, immediate grant and HReady: cpu_req at cycle 0 with addr=32'h0000_0100, HRead_data=32'hDEAD_BEEF -> HTrans=2'b10 and HAddress=32'h100 at cycle 2; cpu_done=1, cpu_rdata=32'hDEAD_BEEF, cpu_error=0 at cycle 4.
- Write with 3-cycle grant delay and 2 HReady wait cycles: wdata=32'h1234_5678 -> HWrite=1 in ADDR; HWrite_data=32'h1234_5678 throughout DATA; cpu_done at cycle 9; cpu_rdata unchanged.
- Slave error: HReady=1 with HResp=2'b01 -> cpu_done=1 with cpu_error=1. Repeat with HResp=2'b10 -> cpu_error=0.
- Timeout: HReady held at 0 -> exactly TIMEOUT cycles in DATA, then cpu_done=1 with cpu_error=1; HBusReq=0 in RESP.
- Request changes while busy: change cpu_addr and cpu_wdata during REQ and DATA -> bus still shows the originally latched values. A cpu_req asserted during RESP is ignored; a cpu_req held into IDLE is accepted.
- Reset mid-transfer: drive rst=0 for one cycle during DATA -> next cycle is IDLE with all outputs at reset values, and no cpu_done is ever produced for the discarded request.
